// File: rtl/mult_arb_pkg.sv
// Shared sizing helpers and types for the multiplier arbiter slice.
package mult_arb_pkg;

  // Largest requester count the arbiter and index helper support.
  localparam int MAX_NREQ = 16;
  localparam int IDX_W    = $clog2(MAX_NREQ);

  // Default geometry of the shared multiplier port.
  localparam int EXP_DEF  = 8;
  localparam int MAN_DEF  = 23;
  localparam int NREQ_DEF = 4;

  // Float word width: {sign, exponent, mantissa}.
  function automatic int fw(input int exp_w, input int man_w);
    return man_w + exp_w + 1;
  endfunction

  // Width of a round-robin pointer over n requesters (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_W = ptr_width(NREQ_DEF);

  // Index of the lowest set bit of a one-hot vector; zero when none is set.
  function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_NREQ - 1; i >= 0; i--) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mult.sv
// Combinational float multiplier: signed exponent field, hidden leading one,
// truncating normalization, flush below range and saturation above range.
// The most negative exponent code encodes zero.
module mult
  import mult_arb_pkg::*;
#(
  parameter int EXP = 8,
  parameter int MAN = 23
) (
  input  logic [fw(EXP, MAN)-1:0] a_i,
  input  logic [fw(EXP, MAN)-1:0] b_i,
  output logic [fw(EXP, MAN)-1:0] p_o
);

  localparam int W      = fw(EXP, MAN);
  localparam int PW     = 2 * (MAN + 1);
  localparam int EMAX_I = 2 ** (EXP - 1) - 1;
  localparam logic [EXP-1:0] ZCODE     = {1'b1, {(EXP-1){1'b0}}};
  localparam logic [EXP-1:0] EMAX_CODE = {1'b0, {(EXP-1){1'b1}}};

  logic                  sign;
  logic [EXP-1:0]        ea;
  logic [EXP-1:0]        eb;
  logic [PW-1:0]         prod;
  logic signed [EXP+1:0] esum;
  logic [MAN-1:0]        man;
  logic                  unused_low;

  // Multiply significands, add exponents, renormalize and clamp to range.
  always_comb begin
    sign = a_i[W-1] ^ b_i[W-1];
    ea   = a_i[W-2:MAN];
    eb   = b_i[W-2:MAN];
    prod = PW'({1'b1, a_i[MAN-1:0]}) * PW'({1'b1, b_i[MAN-1:0]});
    esum = $signed({{2{ea[EXP-1]}}, ea}) + $signed({{2{eb[EXP-1]}}, eb})
         + $signed({{(EXP+1){1'b0}}, prod[PW-1]});
    man  = prod[PW-1] ? prod[PW-2 -: MAN] : prod[PW-3 -: MAN];
    if (ea == ZCODE || eb == ZCODE || int'(esum) < -EMAX_I) begin
      p_o = {1'b0, ZCODE, {MAN{1'b0}}};
    end else if (int'(esum) > EMAX_I) begin
      p_o = {sign, EMAX_CODE, {MAN{1'b1}}};
    end else begin
      p_o = {sign, esum[EXP-1:0], man};
    end
  end

  assign unused_low = ^prod[PW-MAN-3:0];

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first valid requester at or after
// the pointer, then moves the pointer just past the winner.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_valid_i,
  output logic [NREQ-1:0] grant_o
);

  localparam int PW = ptr_width(NREQ);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Scan requesters in rotation order from ptr and pick the first valid one.
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    grant_o = '0;
    ptr_d   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && en_i && !rst && req_valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        if (idx == NREQ - 1) ptr_d = '0;
        else                 ptr_d = PW'(idx + 1);
      end
    end
  end

  // Pointer advances only on a grant and restarts at requester 0 on reset.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mult_arb.sv
// Shares one combinational multiplier between NREQ requesters: one grant per
// cycle, operands registered in S1, product registered in S2 with a one-hot tag.
module mult_arb
  import mult_arb_pkg::*;
#(
  parameter int EXP  = 8,
  parameter int MAN  = 23,
  parameter int NREQ = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*fw(EXP,MAN)-1:0]  req_a,
  input  logic [NREQ*fw(EXP,MAN)-1:0]  req_b,
  output logic [NREQ-1:0]              req_ready,
  output logic                         rsp_valid,
  output logic [NREQ-1:0]              rsp_tag,
  output logic [fw(EXP,MAN)-1:0]       rsp_data,
  output logic                         busy
);

  localparam int W = fw(EXP, MAN);

  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] sel_idx;
  logic [W-1:0]     s1_a_d;
  logic [W-1:0]     s1_b_d;
  logic             s1_v_q;
  logic [W-1:0]     s1_a_q;
  logic [W-1:0]     s1_b_q;
  logic [NREQ-1:0]  s1_tag_q;
  logic [W-1:0]     prod;
  logic             rsp_valid_q;
  logic [NREQ-1:0]  rsp_tag_q;
  logic [W-1:0]     rsp_data_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .req_valid_i (req_valid),
    .grant_o     (grant)
  );

  // Route the granted requester's operand pair towards S1.
  always_comb begin
    sel_idx = oh2idx(MAX_NREQ'(grant));
    s1_a_d  = '0;
    s1_b_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        s1_a_d = req_a[i*W +: W];
        s1_b_d = req_b[i*W +: W];
      end
    end
  end

  // S1 captures operands and tag on a grant; an idle cycle leaves a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_tag_q <= '0;
    end else begin
      s1_v_q <= |grant;
      if (|grant) begin
        s1_a_q   <= s1_a_d;
        s1_b_q   <= s1_b_d;
        s1_tag_q <= grant;
      end
    end
  end

  mult #(.EXP(EXP), .MAN(MAN)) u_mult (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (prod)
  );

  // S2 holds the product and its requester tag for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= s1_v_q;
      rsp_tag_q   <= s1_tag_q;
      rsp_data_q  <= prod;
    end
  end

  // Reset suppresses valid and busy immediately so a discarded result is never seen.
  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q & ~rst;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (s1_v_q | rsp_valid_q) & ~rst;

endmodule

// File: tb/tb_mult_arb.sv
// Self-checking bench for mult_arb: directed sequences, a vector table and a
// randomized run, all compared against a behavioural arbiter/multiplier model.
module tb_mult_arb;
  import mult_arb_pkg::*;

  localparam int EXP  = 8;
  localparam int MAN  = 23;
  localparam int NREQ = 4;
  localparam int W    = fw(EXP, MAN);

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [NREQ-1:0]     rsp_tag;
  logic [W-1:0]        rsp_data;
  logic                busy;

  mult_arb #(.EXP(EXP), .MAN(MAN), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              due;
    logic [NREQ-1:0] tag;
    logic [W-1:0]    data;
  } rsp_t;

  typedef struct {
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] r;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    int              p;
    logic [W-1:0]    d;
  } vec_t;

  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              mPtr = 0;
  rsp_t            pending[$];
  logic [NREQ-1:0] lastGrant;
  logic [NREQ-1:0] obsReady;
  logic            obsValid;
  logic [NREQ-1:0] obsTag;
  logic [W-1:0]    obsData;
  logic            obsBusy;
  logic [PTR_W-1:0] obsPtr;
  vec_t            tbl[8];

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [NREQ-1:0] v);
    rst       = r;
    en        = e;
    req_valid = v;
  endtask

  // Float product from the number values: (1+m/2^23) * 2^e per operand.
  function automatic logic [W-1:0] modelMult(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [7:0] ea8;
    logic signed [7:0] eb8;
    real ma, mb, x;
    int  e, man;
    logic s;
    ea8 = a[30:23];
    eb8 = b[30:23];
    s   = a[31] ^ b[31];
    if (ea8 == -8'sd128 || eb8 == -8'sd128) return {1'b0, 8'h80, 23'h0};
    ma = a[22:0];
    mb = b[22:0];
    x  = (1.0 + ma / 8388608.0) * (1.0 + mb / 8388608.0);
    e  = int'(ea8) + int'(eb8);
    if (x >= 2.0) begin
      x = x / 2.0;
      e = e + 1;
    end
    if (e < -127) return {1'b0, 8'h80, 23'h0};
    if (e > 127)  return {s, 8'h7F, 23'h7FFFFF};
    man = $rtoi((x - 1.0) * 8388608.0);
    return {s, e[7:0], man[22:0]};
  endfunction

  // First valid requester in the order ptr, ptr+1, ... wrapping at NREQ.
  function automatic logic [NREQ-1:0] modelGrant(input logic [NREQ-1:0] v, input int p,
                                                 input logic r, input logic e);
    logic [NREQ-1:0] g;
    g = '0;
    if (r || !e) return g;
    for (int k = 0; k < NREQ; k++) begin
      if (g == '0 && v[(p + k) % NREQ]) g[(p + k) % NREQ] = 1'b1;
    end
    return g;
  endfunction

  // One clock cycle: check outputs mid-cycle against the model, then advance it.
  task automatic step();
    logic [NREQ-1:0] g;
    logic            ev;
    int              gi;
    rsp_t            item;
    @(negedge clk);
    g        = modelGrant(req_valid, mPtr, rst, en);
    obsReady = req_ready;
    obsValid = rsp_valid;
    obsTag   = rsp_tag;
    obsData  = rsp_data;
    obsBusy  = busy;
    checkOutput("req_ready", req_ready, g);
    if (rst) begin
      checkOutput("rsp_valid_rst", rsp_valid, 0);
      checkOutput("busy_rst", busy, 0);
      pending.delete();
      mPtr = 0;
    end else begin
      ev = (pending.size() > 0 && pending[0].due == cyc);
      checkOutput("busy", busy, pending.size() > 0);
      checkOutput("rsp_valid", rsp_valid, ev);
      if (ev) begin
        checkOutput("rsp_tag", rsp_tag, pending[0].tag);
        checkOutput("rsp_data", rsp_data, pending[0].data);
        void'(pending.pop_front());
      end
      if (g != '0) begin
        gi        = int'(oh2idx(MAX_NREQ'(g)));
        item.due  = cyc + 2;
        item.tag  = g;
        item.data = modelMult(req_a[gi*W +: W], req_b[gi*W +: W]);
        pending.push_back(item);
        mPtr = (gi + 1) % NREQ;
      end
    end
    lastGrant = g;
    cyc++;
    @(posedge clk);
    #1;
    obsPtr = dut.u_arb.ptr_q;
  endtask

  function automatic logic [W-1:0] randOp();
    logic [7:0] e8;
    if ($urandom_range(0, 3) == 0) return W'($urandom);
    e8 = 8'($urandom_range(0, 60)) - 8'd30;
    return {1'b0 ^ ($urandom_range(0, 1) == 1), e8, 23'($urandom)};
  endfunction

  initial begin
    logic [NREQ-1:0] enGrants[8];
    logic            enSeq[8];
    int              gi;

    tbl[0] = '{4'b0100, 4'b0100, 32'h00C0_0000, 32'h0140_0000, 3, 32'h0210_0000};
    tbl[1] = '{4'b0011, 4'b0001, 32'h3F80_0000, 32'h0000_0000, 1, 32'h3F80_0000};
    tbl[2] = '{4'b0010, 4'b0010, 32'h3F80_0000, 32'h0080_0000, 2, 32'h3FFF_FFFF};
    tbl[3] = '{4'b1111, 4'b0100, 32'h4E00_0000, 32'h4E00_0000, 3, 32'h4000_0000};
    tbl[4] = '{4'b1011, 4'b1000, 32'h8000_0000, 32'h0000_0000, 0, 32'h8000_0000};
    tbl[5] = '{4'b0011, 4'b0001, 32'h00FF_FFFF, 32'h00FF_FFFF, 1, 32'h01FF_FFFE};
    tbl[6] = '{4'b0010, 4'b0010, 32'h0000_0000, 32'h0000_0000, 2, 32'h0000_0000};
    tbl[7] = '{4'b0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 2, 32'h0000_0000};

    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'($urandom);
      req_b[i*W +: W] = W'($urandom);
    end

    // Reset held with everyone requesting: nothing granted, nothing busy.
    applyStimulus(1'b1, 1'b1, '1);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("reset_ready", obsReady, 0);
      checkOutput("reset_valid", obsValid, 0);
      checkOutput("reset_busy", obsBusy, 0);
    end

    // All four requesting continuously: grants rotate 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b1, (k < 8) ? 4'b1111 : 4'b0000);
      step();
      if (k < 8) checkOutput("rotate_grant", obsReady, 4'b0001 << (k % 4));
      if (k >= 2) begin
        checkOutput("rotate_valid", obsValid, 1);
        checkOutput("rotate_tag", obsTag, 4'b0001 << ((k - 2) % 4));
      end
    end

    // Vector table: wrap, skip, idle, and multiplier boundary values.
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        applyStimulus(1'b0, 1'b1, tbl[k].v);
        for (int i = 0; i < NREQ; i++) begin
          req_a[i*W +: W] = 32'h0100_0000 + 32'(i);
          req_b[i*W +: W] = 32'h0180_0000 + 32'(i);
        end
        if (tbl[k].r != '0) begin
          gi = int'(oh2idx(MAX_NREQ'(tbl[k].r)));
          req_a[gi*W +: W] = tbl[k].a;
          req_b[gi*W +: W] = tbl[k].b;
        end
      end else begin
        applyStimulus(1'b0, 1'b1, '0);
      end
      step();
      if (k < 8) begin
        checkOutput("tbl_ready", obsReady, tbl[k].r);
        checkOutput("tbl_ptr", obsPtr, tbl[k].p);
      end
      if (k >= 2) begin
        checkOutput("tbl_valid", obsValid, tbl[k-2].r != '0);
        if (tbl[k-2].r != '0) begin
          checkOutput("tbl_tag", obsTag, tbl[k-2].r);
          checkOutput("tbl_data", obsData, tbl[k-2].d);
        end
      end
    end

    // Enable dropped for two cycles during contention; ptr holds at 0.
    enGrants = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    enSeq    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, enSeq[k], '1);
      step();
      checkOutput("en_grant", obsReady, enGrants[k]);
      if (k == 2 || k == 3) begin
        checkOutput("en_drain_valid", obsValid, 1);
        checkOutput("en_drain_tag", obsTag, enGrants[k-2]);
        checkOutput("en_hold_ptr", obsPtr, 0);
      end
    end
    applyStimulus(1'b0, 1'b1, '0);
    step();
    step();

    // Reset pulse with S1 and S2 both occupied: both results are discarded.
    applyStimulus(1'b0, 1'b1, '1);
    step();
    step();
    applyStimulus(1'b1, 1'b1, '1);
    step();
    checkOutput("rstpulse_ready", obsReady, 0);
    checkOutput("rstpulse_valid", obsValid, 0);
    applyStimulus(1'b0, 1'b1, '1);
    step();
    checkOutput("rstpulse_after_valid", obsValid, 0);
    checkOutput("rstpulse_after_busy", obsBusy, 0);
    checkOutput("rstpulse_first_grant", obsReady, 4'b0001);
    applyStimulus(1'b0, 1'b1, '0);
    step();
    checkOutput("rstpulse_s1_dropped", obsValid, 0);
    step();
    step();

    // Randomized traffic with held requests, enable gaps and reset pulses.
    req_valid = '0;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      en  = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i]    = 1'b1;
          req_a[i*W +: W] = randOp();
          req_b[i*W +: W] = randOp();
        end
      end
      step();
      req_valid = req_valid & ~lastGrant;
    end
    applyStimulus(1'b0, 1'b1, '0);
    for (int k = 0; k < 3; k++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_arb.md
# mult_arb

Round-robin arbiter and two-stage pipeline that shares one floating-point `mult` instance between NREQ requesters, typically the biquad sections of the IIR filter. One request is granted per cycle, its operands are registered, multiplied and normalized by `mult`, and the product is returned two cycles later with a one-hot tag identifying the requester.

## Interface
- EXP, 8, exponent width (signed two's complement field)
- MAN, 23, mantissa width; float word W = MAN+EXP+1 bits, {sign, exponent, mantissa}
- NREQ, 4, number of requesters (2..16)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  grant enable; low stops new grants, pipeline still drains
- req_valid  in  NREQ  per-requester request
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_ready  out  NREQ  one-hot grant, combinational from req_valid, en and pointer
- rsp_valid  out  1  product valid
- rsp_tag  out  NREQ  one-hot requester of the current product
- rsp_data  out  W  product, `mult` output format
- busy  out  1  any pipeline stage occupied

## Operation
- Handshake: transfer on req_valid[i] & req_ready[i]. After raising req_valid[i], requester i holds it and its operands stable until the transfer. req_ready never asserts for a requester whose req_valid is low.
- Arbitration: rotating priority starting at pointer `ptr`, in the order ptr, ptr+1, …, NREQ-1, 0, …. The first valid requester in that order is granted. With en=0 or rst=1, req_ready = 0.
- Pointer: after a grant to i, ptr <= (i+1) mod NREQ, wrapping from NREQ-1 to 0. ptr is unchanged when no grant occurs.
- Stage 1 (S1): on grant, register A, B and the one-hot tag, and set s1_v. Otherwise s1_v <= 0.
- The combinational `mult` instance is fed from the S1 registers.
- Stage 2 (S2): rsp_data <= mult output, rsp_tag <= S1 tag, rsp_valid <= s1_v.
- No response backpressure: a requester must accept rsp_data in the cycle that rsp_valid is high and rsp_tag matches it.
- busy = s1_v | rsp_valid.
- No arithmetic inside the block: the exponent/mantissa rules, underflow flush and normalization come entirely from `mult`. Product bits pass through unmodified.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_tag = 0, rsp_data = 0, busy = 0, ptr = 0, s1_v = 0.
- Latency: a grant in cycle t gives rsp_valid high in cycle t+2.
- Throughput: one product per cycle while any request is pending.
- Fairness: a continuously valid requester is granted within NREQ cycles of raising req_valid (en=1).
- Simultaneous requests: exactly one grant per cycle. The rest wait and keep req_valid high.
- en falling while requests are pending: no grant that cycle. In-flight S1/S2 data still completes, and ptr holds.
- Reset asserted mid-operation: S1 and S2 contents are discarded and no response is emitted for them. The next grant can occur in the first cycle after rst deasserts.
- A requester may re-request in the cycle after its transfer. Its next grant then follows the rotation.

## Structure
- Package `mult_arb_pkg`:
  - function `fw(EXP,MAN)` returning W
  - clog2-based pointer width constant
  - one-hot-to-index function shared with the bench
- Sub-module `rr_arbiter`:
  - combinational rotating-priority pick of req_valid & en against ptr
  - registered ptr update, with its own rst
- `mult_arb` contains `rr_arbiter`, the operand mux, the S1/S2 registers and one `mult` instance.

## Test plan
- Reset: hold rst 3 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, busy=0 throughout. The first grant, one cycle after rst falls, goes to requester 0.
- Single requester: req_valid=4'b0100, A=32'h00C0_0000, B=32'h0140_0000 -> req_ready=4'b0100 at t, rsp_valid=1 and rsp_tag=4'b0100 at t+2, rsp_data equal to the bench model of `mult` on A and B.
- All four requesting continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3. rsp_tag follows the same sequence two cycles later, with rsp_valid held high.
- Pointer wrap and skip: ptr=3, req_valid=4'b0011 -> grant 0, then 1, then idle. ptr reads 2 afterwards.
- en pulled low for 2 cycles during contention -> no req_ready during those cycles. Two pending responses still emerge, rotation resumes at the held ptr, and no requester is dropped.
- rst pulsed 1 cycle with S1 and S2 both valid -> neither result appears on rsp_valid, and busy=0 the cycle after reset.
